// File: rtl/msg_sink_deframer.sv
// Portal msgSink deframer: header/payload parsing into a 2-entry output buffer.
// Optional stats counters: define MSG_DEFRAMER_STATS_EN.

// Generic small FIFO with registered storage; DEPTH must be a power of two.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: full blocks push; pop only when pop_vld & pop_rdy.
module msg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         full,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_vld = (count != '0);
    assign pop_dat = mem[rd_ptr];
    assign push_ok = push_vld & ~full;
    assign pop_ok  = pop_vld & pop_rdy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Parses header beat {method, len} then len-1 payload beats into tagged words.
// Latency: an accepted payload beat appears on out_* one cycle later (buffer empty).
// Backpressure: sink_dst_rdy is registered-only, low when the 2-entry buffer is full.
module msg_sink_deframer #(
    parameter int NUM_METHODS = 16,
    parameter int METHOD_W    = 4,
    parameter int MAX_WORDS   = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                sink_src_rdy,
    input  logic [31:0]         sink_beat,
    output logic                sink_dst_rdy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [METHOD_W-1:0] out_method,
    output logic [31:0]         out_data,
    output logic                out_last,
    output logic                out_hdr_only,
    output logic                err_pulse
`ifdef MSG_DEFRAMER_STATS_EN
    ,
    output logic [31:0]         stat_msgs,
    output logic [15:0]         stat_drops
`endif
);
    typedef struct packed {
        logic [METHOD_W-1:0] method;
        logic [31:0]         data;
        logic                last;
        logic                hdr_only;
    } word_t;

    typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

    state_t              state;
    logic [15:0]         remaining;
    logic [METHOD_W-1:0] cur_method;
    logic                rdy_en;
    logic                fifo_full;
    logic                beat_acc;
    logic [15:0]         hdr_method;
    logic [15:0]         hdr_len;
    logic                len_bad;
    logic                method_bad;
    logic                push;
    word_t               push_word;
    word_t               head;

    assign hdr_method   = sink_beat[31:16];
    assign hdr_len      = sink_beat[15:0];
    assign len_bad      = (hdr_len == 16'd0) || (hdr_len > 16'(MAX_WORDS));
    assign method_bad   = (hdr_method >= 16'(NUM_METHODS));

    // rdy_en keeps dst_rdy low while reset is held and for the release cycle.
    assign sink_dst_rdy = rdy_en & ~fifo_full;
    assign beat_acc     = sink_src_rdy & sink_dst_rdy;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (beat_acc) begin
            case (state)
                S_HDR: begin
                    if (!len_bad && !method_bad && hdr_len == 16'd1) begin
                        push               = 1'b1;
                        push_word.method   = hdr_method[METHOD_W-1:0];
                        push_word.last     = 1'b1;
                        push_word.hdr_only = 1'b1;
                    end
                end
                S_PAY: begin
                    push             = 1'b1;
                    push_word.method = cur_method;
                    push_word.data   = sink_beat;
                    push_word.last   = (remaining == 16'd1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_HDR;
            remaining  <= 16'd0;
            cur_method <= '0;
            err_pulse  <= 1'b0;
            rdy_en     <= 1'b0;
        end else begin
            rdy_en    <= 1'b1;
            err_pulse <= 1'b0;
            if (beat_acc) begin
                case (state)
                    S_HDR: begin
                        if (len_bad) begin
                            err_pulse <= 1'b1;
                        end else if (method_bad) begin
                            err_pulse <= 1'b1;
                            if (hdr_len != 16'd1) begin
                                remaining <= hdr_len - 16'd1;
                                state     <= S_DROP;
                            end
                        end else if (hdr_len != 16'd1) begin
                            cur_method <= hdr_method[METHOD_W-1:0];
                            remaining  <= hdr_len - 16'd1;
                            state      <= S_PAY;
                        end
                    end
                    S_PAY, S_DROP: begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= S_HDR;
                    end
                    default: state <= S_HDR;
                endcase
            end
        end
    end

    msg_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (2)
    ) u_out_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push_vld (push),
        .push_dat (push_word),
        .full     (fifo_full),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head)
    );

    assign out_method   = head.method;
    assign out_data     = head.data;
    assign out_last     = head.last;
    assign out_hdr_only = head.hdr_only;

`ifdef MSG_DEFRAMER_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_msgs  <= 32'd0;
            stat_drops <= 16'd0;
        end else begin
            if (out_valid && out_ready && out_last) stat_msgs <= stat_msgs + 32'd1;
            if (err_pulse && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
        end
    end
`endif
endmodule
